// File: rtl/truth_table_sequencer_if.sv
// Handshake and result bundle between the sweep controller and the
// two implementations under comparison.
interface truth_table_sequencer_if #(
  parameter int N = 2
);
  logic                 start;
  logic                 a_in;
  logic                 b_in;
  logic [N-1:0]         x;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N:0]           err_count;
  logic [N-1:0]         first_err;
  logic                 first_err_valid;
  logic [(1<<N)-1:0]    table_a;

  modport master (
    input  start, a_in, b_in,
    output x, busy, done, pass, err_count, first_err, first_err_valid, table_a
  );

  modport slave (
    output start, a_in, b_in,
    input  x, busy, done, pass, err_count, first_err, first_err_valid, table_a
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Clocked exhaustive sweep of an N-input function: drives every minterm,
// compares two implementations against each other and a golden table.
module truth_table_sequencer #(
  parameter int                N      = 2,
  parameter int                SETTLE = 1,
  parameter logic [(1<<N)-1:0] EXPECT = 4'b0001
) (
  input  logic                       clk,
  input  logic                       reset,
  truth_table_sequencer_if.master    bus
);
  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N-1:0]    M_LAST   = '1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  state_t              state_q, state_n;
  logic [N-1:0]        m_q, m_n;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                pass_q, pass_n;
  logic [N:0]          err_q, err_n;
  logic [N-1:0]        fe_q, fe_n;
  logic                fev_q, fev_n;
  logic [(1<<N)-1:0]   tbl_q, tbl_n;
  logic                mismatch;

  // Case inequality so an X/Z on either input is reported as a mismatch.
  always_comb mismatch = (bus.a_in !== bus.b_in) || (bus.a_in !== EXPECT[m_q]);

  always_comb begin
    state_n = state_q;
    m_n     = m_q;
    cnt_n   = cnt_q;
    busy_n  = busy_q;
    done_n  = done_q;
    pass_n  = pass_q;
    err_n   = err_q;
    fe_n    = fe_q;
    fev_n   = fev_q;
    tbl_n   = tbl_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_n = ST_SETTLE;
          m_n     = '0;
          cnt_n   = CNT_LOAD;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          err_n   = '0;
          fe_n    = '0;
          fev_n   = 1'b0;
          tbl_n   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_n = ST_SAMPLE;
        else             cnt_n   = cnt_q - CW'(1);
      end
      ST_SAMPLE: begin
        tbl_n[m_q] = bus.a_in;
        if (mismatch) begin
          err_n = err_q + (N+1)'(1);
          if (!fev_q) begin
            fe_n  = m_q;
            fev_n = 1'b1;
          end
        end
        // Terminal check before increment: m never wraps, x stays on the last minterm.
        if (m_q == M_LAST) begin
          state_n = ST_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end else begin
          m_n     = m_q + N'(1);
          cnt_n   = CNT_LOAD;
          state_n = ST_SETTLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fe_q    <= '0;
      fev_q   <= 1'b0;
      tbl_q   <= '0;
    end else begin
      state_q <= state_n;
      m_q     <= m_n;
      cnt_q   <= cnt_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
      err_q   <= err_n;
      fe_q    <= fe_n;
      fev_q   <= fev_n;
      tbl_q   <= tbl_n;
    end
  end

  assign bus.x               = m_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err       = fe_q;
  assign bus.first_err_valid = fev_q;
  assign bus.table_a         = tbl_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: three sequencer instances (nominal, wrong golden table,
// SETTLE=3) each exercising a two-input NOR pair.
module tb_truth_table_sequencer;
  logic clk;
  logic reset;
  logic fault;
  int   checks;
  int   failures;

  truth_table_sequencer_if #(.N(2)) if_nom ();
  truth_table_sequencer_if #(.N(2)) if_exp ();
  truth_table_sequencer_if #(.N(2)) if_s3  ();

  truth_table_sequencer #(.N(2), .SETTLE(1), .EXPECT(4'b0001)) dut_nom (
    .clk(clk), .reset(reset), .bus(if_nom.master));
  truth_table_sequencer #(.N(2), .SETTLE(1), .EXPECT(4'b1000)) dut_exp (
    .clk(clk), .reset(reset), .bus(if_exp.master));
  truth_table_sequencer #(.N(2), .SETTLE(3), .EXPECT(4'b0001)) dut_s3 (
    .clk(clk), .reset(reset), .bus(if_s3.master));

  // A is gate-level NOR, B is the expression form; fault sticks B at 0.
  assign if_nom.a_in = ~(if_nom.x[1] | if_nom.x[0]);
  assign if_nom.b_in = fault ? 1'b0 : (~if_nom.x[1] & ~if_nom.x[0]);
  assign if_exp.a_in = ~(if_exp.x[1] | if_exp.x[0]);
  assign if_exp.b_in = ~if_exp.x[1] & ~if_exp.x[0];
  assign if_s3.a_in  = ~(if_s3.x[1] | if_s3.x[0]);
  assign if_s3.b_in  = ~if_s3.x[1] & ~if_s3.x[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_nom.x, if_nom.busy, if_nom.done, if_nom.pass} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=00000", {if_nom.x, if_nom.busy, if_nom.done, if_nom.pass});
    end
    checks++;
    if ({if_nom.err_count, if_nom.first_err, if_nom.first_err_valid, if_nom.table_a} !== 10'b0) begin
      failures++;
      $display("FAIL reset_results got=%b exp=0", {if_nom.err_count, if_nom.first_err, if_nom.first_err_valid, if_nom.table_a});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (if_nom.busy !== 1'b0 || if_nom.x !== 2'd0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b x=%0d exp busy=0 x=0", if_nom.busy, if_nom.x);
    end
  endtask

  // Nominal 8-cycle sweep on dut_nom; x, busy, done followed every cycle.
  task automatic sweep_nom(input string tag);
    int ex;
    if_nom.start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) if_nom.start = 1'b0;
      ex = (c - 1) / 2;
      if (ex > 3) ex = 3;
      checks++;
      if (if_nom.x !== 2'(ex) || if_nom.busy !== (c <= 8) || if_nom.done !== (c == 9)) begin
        failures++;
        $display("FAIL %s_seq c=%0d x=%0d busy=%b done=%b exp x=%0d busy=%b done=%b",
                 tag, c, if_nom.x, if_nom.busy, if_nom.done, ex, (c <= 8), (c == 9));
      end
      if (c == 1) begin
        checks++;
        if ({if_nom.err_count, if_nom.first_err_valid, if_nom.table_a, if_nom.pass} !== 9'b0) begin
          failures++;
          $display("FAIL %s_cleared got=%b exp=0", tag,
                   {if_nom.err_count, if_nom.first_err_valid, if_nom.table_a, if_nom.pass});
        end
      end
    end
  endtask

  task automatic test_nominal;
    fault = 1'b0;
    sweep_nom("nominal");
    checks++;
    if (if_nom.pass !== 1'b1 || if_nom.err_count !== 3'd0 || if_nom.table_a !== 4'b0001 || if_nom.first_err_valid !== 1'b0) begin
      failures++;
      $display("FAIL nominal_result pass=%b err=%0d tbl=%b fev=%b exp 1 0 0001 0",
               if_nom.pass, if_nom.err_count, if_nom.table_a, if_nom.first_err_valid);
    end
  endtask

  task automatic test_stuck_at;
    fault = 1'b1;
    sweep_nom("stuck");
    checks++;
    if (if_nom.err_count !== 3'd1 || if_nom.first_err !== 2'd0 || if_nom.first_err_valid !== 1'b1) begin
      failures++;
      $display("FAIL stuck_err err=%0d fe=%0d fev=%b exp 1 0 1", if_nom.err_count, if_nom.first_err, if_nom.first_err_valid);
    end
    checks++;
    if (if_nom.pass !== 1'b0 || if_nom.table_a !== 4'b0001) begin
      failures++;
      $display("FAIL stuck_pass pass=%b tbl=%b exp 0 0001", if_nom.pass, if_nom.table_a);
    end
  endtask

  task automatic test_restart_from_done;
    fault = 1'b0;
    sweep_nom("restart");
    checks++;
    if (if_nom.pass !== 1'b1 || if_nom.err_count !== 3'd0 || if_nom.first_err_valid !== 1'b0) begin
      failures++;
      $display("FAIL restart_result pass=%b err=%0d fev=%b exp 1 0 0", if_nom.pass, if_nom.err_count, if_nom.first_err_valid);
    end
  endtask

  task automatic test_wrong_golden;
    if_exp.start = 1'b1;
    @(negedge clk);
    if_exp.start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (if_exp.done !== 1'b1 || if_exp.err_count !== 3'd2 || if_exp.first_err !== 2'd0 || if_exp.pass !== 1'b0) begin
      failures++;
      $display("FAIL golden_result done=%b err=%0d fe=%0d pass=%b exp 1 2 0 0",
               if_exp.done, if_exp.err_count, if_exp.first_err, if_exp.pass);
    end
    checks++;
    if (if_exp.table_a !== 4'b0001 || if_exp.first_err_valid !== 1'b1) begin
      failures++;
      $display("FAIL golden_table tbl=%b fev=%b exp 0001 1", if_exp.table_a, if_exp.first_err_valid);
    end
  endtask

  task automatic test_settle3;
    int ex;
    if_s3.start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      ex = (c - 1) / 4;
      if (ex > 3) ex = 3;
      checks++;
      if (if_s3.x !== 2'(ex) || if_s3.busy !== (c <= 16) || if_s3.done !== (c == 17)) begin
        failures++;
        $display("FAIL settle3_seq c=%0d x=%0d busy=%b done=%b exp x=%0d busy=%b done=%b",
                 c, if_s3.x, if_s3.busy, if_s3.done, ex, (c <= 16), (c == 17));
      end
      // Stray starts in front of edges 2 and 9 land in SETTLE and must be ignored.
      if_s3.start = (c == 2 || c == 9);
    end
    checks++;
    if (if_s3.pass !== 1'b1 || if_s3.err_count !== 3'd0 || if_s3.table_a !== 4'b0001) begin
      failures++;
      $display("FAIL settle3_result pass=%b err=%0d tbl=%b exp 1 0 0001", if_s3.pass, if_s3.err_count, if_s3.table_a);
    end
  endtask

  task automatic test_reset_mid;
    fault = 1'b0;
    if_nom.start = 1'b1;
    @(negedge clk);
    if_nom.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (if_nom.x !== 2'd1 || if_nom.table_a !== 4'b0001) begin
      failures++;
      $display("FAIL mid_pre x=%0d tbl=%b exp 1 0001", if_nom.x, if_nom.table_a);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({if_nom.busy, if_nom.done, if_nom.x, if_nom.err_count, if_nom.table_a, if_nom.first_err_valid} !== 12'b0) begin
      failures++;
      $display("FAIL mid_cleared got=%b exp=0",
               {if_nom.busy, if_nom.done, if_nom.x, if_nom.err_count, if_nom.table_a, if_nom.first_err_valid});
    end
    @(negedge clk);
    checks++;
    if (if_nom.busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_stays_idle busy=%b exp 0", if_nom.busy);
    end
    sweep_nom("post_reset");
    checks++;
    if (if_nom.pass !== 1'b1 || if_nom.table_a !== 4'b0001) begin
      failures++;
      $display("FAIL post_reset_result pass=%b tbl=%b exp 1 0001", if_nom.pass, if_nom.table_a);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    fault        = 1'b0;
    reset        = 1'b1;
    if_nom.start = 1'b0;
    if_exp.start = 1'b0;
    if_s3.start  = 1'b0;
    test_reset();
    test_nominal();
    test_stuck_at();
    test_restart_from_done();
    test_wrong_golden();
    test_settle3();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
